// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - default register-file geometry and address-width helper
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;

  function automatic int rf_aw(input int n);
    int a;
    a = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) a = i + 1;
    end
    return a;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write scoreboard with registered population count
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = NWR_DEF,
  parameter int AW   = rf_aw(NREG)
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [AW:0]       busy_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  // Clears are applied before the set so an issue beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (we[w]) busy_d[wa[w*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with scoreboard
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF,
  localparam int AW  = rf_aw(NREG)
) (
  input  logic                clk,
  input  logic                res,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;
  logic            rd_hit;

  // Ascending port order lets the highest-index writer win on collisions.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWR; w++) begin
      if (we[w]) regs_d[wa[w*AW +: AW]] = wd[w*XLEN +: XLEN];
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    rd_addr = '0;
    rd_val  = '0;
    rd_hit  = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      rd_addr = ra[p*AW +: AW];
      rd_val  = regs_q[rd_addr];
      rd_hit  = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && (wa[w*AW +: AW] == rd_addr) && (rd_addr != '0)) begin
          rd_hit = 1'b1;
          rd_val = wd[w*XLEN +: XLEN];
        end
      end
`endif
      rd[p*XLEN +: XLEN] = rd_val;
      rd_busy[p]         = busy_vec[rd_addr] & ~rd_hit;
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .res      (res),
    .we       (we),
    .wa       (wa),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb against a behavioural model
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                res;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREG-1:0]     busy_vec;
  logic [AW:0]         busy_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit model_ok  = 0;

  logic [XLEN-1:0] m_reg [NREG];
  logic [NREG-1:0] m_busy;

  reg_file_sb dut (
    .clk      (clk),
    .res      (res),
    .ra       (ra),
    .rd       (rd),
    .rd_busy  (rd_busy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_in();
    res = 0; ra = '0; we = '0; wa = '0; wd = '0; iss_en = 0; iss_addr = '0;
  endtask

  // Expected read of port p from the model and the current inputs.
  function automatic logic [XLEN:0] model_read(input int p);
    int a;
    logic [XLEN-1:0] v;
    logic hit;
    a = int'(ra[p*AW +: AW]);
    v = m_reg[a];
    hit = 0;
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (we[w] && int'(wa[w*AW +: AW]) == a && a != 0) begin
        hit = 1; v = wd[w*XLEN +: XLEN];
      end
`endif
    return {m_busy[a] & ~hit, v};
  endfunction

  // Compare outputs against the model, then advance one edge and update the model.
  task automatic tick();
    logic [XLEN:0] e;
    #1;
    if (model_ok) begin
      for (int p = 0; p < NRD; p++) begin
        e = model_read(p);
        check($sformatf("rd[%0d]", p), 64'(rd[p*XLEN +: XLEN]), 64'(e[XLEN-1:0]));
        check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(e[XLEN]));
      end
      check("busy_vec", 64'(busy_vec), 64'(m_busy));
      check("busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
    end
    @(posedge clk);
    if (res) begin
      for (int r = 0; r < NREG; r++) m_reg[r] = '0;
      m_busy = '0;
      model_ok = 1;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (we[w] && wa[w*AW +: AW] != 0) begin
          m_reg[wa[w*AW +: AW]] = wd[w*XLEN +: XLEN];
          m_busy[wa[w*AW +: AW]] = 1'b0;
        end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  initial begin
    clear_in();
    @(negedge clk); res = 1; tick();

    // Reset state
    @(negedge clk); clear_in(); #1;
    check("reset busy_vec", 64'(busy_vec), 64'h0);
    check("reset busy_cnt", 64'(busy_cnt), 64'h0);
    tick();

    // r5 <= DEADBEEF, then read
    @(negedge clk); clear_in(); we = 2'b01; wa[0 +: AW] = 5; wd[0 +: XLEN] = 32'hDEADBEEF; tick();
    @(negedge clk); clear_in(); ra[0 +: AW] = 5; #1;
    check("r5 readback", 64'(rd[0 +: XLEN]), 64'hDEADBEEF);
    tick();

    // Writes to r0 are dropped
    @(negedge clk); clear_in(); we = 2'b01; wa[0 +: AW] = 0; wd[0 +: XLEN] = 32'h1234; tick();
    @(negedge clk); clear_in(); ra[0 +: AW] = 0; #1;
    check("r0 reads zero", 64'(rd[0 +: XLEN]), 64'h0);
    check("r0 never busy", 64'(busy_vec[0]), 64'h0);
    tick();

    // Same-register collision: port 1 wins
    @(negedge clk); clear_in(); we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'hBB, 32'hAA}; tick();
    @(negedge clk); clear_in(); ra = {5'd7, 5'd7}; #1;
    check("r7 collision p0", 64'(rd[0 +: XLEN]), 64'hBB);
    check("r7 collision p1", 64'(rd[XLEN +: XLEN]), 64'hBB);
    tick();

    // Scoreboard sequence
    @(negedge clk); clear_in(); iss_en = 1; iss_addr = 3; tick();
    @(negedge clk); clear_in(); iss_en = 1; iss_addr = 9; tick();
    @(negedge clk); clear_in(); #1;
    check("busy_cnt after 2 issues", 64'(busy_cnt), 64'd2);
    we = 2'b01; wa[0 +: AW] = 3; wd[0 +: XLEN] = 32'h33; tick();
    @(negedge clk); clear_in(); ra[0 +: AW] = 3; #1;
    check("busy_cnt after wb r3", 64'(busy_cnt), 64'd1);
    check("rd_busy r3 after wb", 64'(rd_busy[0]), 64'd0);
    iss_en = 1; iss_addr = 9; we = 2'b10; wa[AW +: AW] = 9; wd[XLEN +: XLEN] = 32'h99; tick();
    @(negedge clk); clear_in(); ra[0 +: AW] = 9; #1;
    check("issue beats wb r9", 64'(busy_vec[9]), 64'd1);
    check("r9 data written", 64'(rd[0 +: XLEN]), 64'h99);
    tick();

    // Same-cycle write and read of r4 (r4 still holds 0)
    @(negedge clk); clear_in(); we = 2'b01; wa[0 +: AW] = 4; wd[0 +: XLEN] = 32'h55; ra[0 +: AW] = 4; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass rd r4", 64'(rd[0 +: XLEN]), 64'h55);
    check("bypass rd_busy r4", 64'(rd_busy[0]), 64'd0);
`else
    check("no bypass rd r4", 64'(rd[0 +: XLEN]), 64'h0);
`endif
    tick();

    // Issue r1..r31, then reset
    for (int r = 1; r < NREG; r++) begin
      @(negedge clk); clear_in(); iss_en = 1; iss_addr = AW'(r); tick();
    end
    @(negedge clk); clear_in(); #1;
    check("busy_cnt full", 64'(busy_cnt), 64'd31);
    check("busy_vec full", 64'(busy_vec), 64'hFFFF_FFFE);
    res = 1; iss_en = 1; iss_addr = 2; we = 2'b01; wa[0 +: AW] = 6; wd[0 +: XLEN] = 32'h66; tick();
    @(negedge clk); clear_in(); #1;
    check("post-reset busy_vec", 64'(busy_vec), 64'h0);
    check("post-reset busy_cnt", 64'(busy_cnt), 64'h0);
    for (int r = 0; r < NREG; r += 2) begin
      ra = {AW'(r + 1), AW'(r)}; #1;
      check($sformatf("post-reset r%0d", r), 64'(rd[0 +: XLEN]), 64'h0);
      check($sformatf("post-reset r%0d", r + 1), 64'(rd[XLEN +: XLEN]), 64'h0);
    end
    tick();
    // Writeback after reset to a non-busy register
    @(negedge clk); clear_in(); we = 2'b01; wa[0 +: AW] = 2; wd[0 +: XLEN] = 32'h22; ra[0 +: AW] = 2; tick();
    @(negedge clk); clear_in(); ra[0 +: AW] = 2; #1;
    check("wb non-busy data", 64'(rd[0 +: XLEN]), 64'h22);
    check("wb non-busy busy", 64'(busy_vec[2]), 64'h0);
    tick();

    // Randomized traffic, addresses biased into a small window for collisions
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); clear_in();
      res = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NRD; p++)
        ra[p*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      for (int w = 0; w < NWR; w++) begin
        we[w] = ($urandom_range(0, 2) == 0);
        wa[w*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
        wd[w*XLEN +: XLEN] = $urandom;
      end
      iss_en = ($urandom_range(0, 1) == 0);
      iss_addr = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
